// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM register, branch resolution, req/ack data-memory
// access with upstream stall, and the MEM/WB register feeding writeback.
module mem_stage #(
    parameter int word_size = 32,
    parameter int reg_size  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic [word_size-1:0] alu_result_in,
    input  logic                 zero_in,
    input  logic [word_size-1:0] add_result_in,
    input  logic [word_size-1:0] write_data_in,
    input  logic [reg_size-1:0]  dest_reg_in,
    input  logic [2:0]           mem_ctrl_in,
    input  logic [1:0]           wb_ctrl_in,
    input  logic                 flush,
    output logic                 stall,
    output logic                 pc_src,
    output logic [word_size-1:0] branch_target,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [word_size-1:0] dmem_addr,
    output logic [word_size-1:0] dmem_wdata,
    input  logic [word_size-1:0] dmem_rdata,
    input  logic                 dmem_ack,
    output logic                 wb_valid,
    output logic [word_size-1:0] wb_read_data,
    output logic [word_size-1:0] wb_alu_result,
    output logic [reg_size-1:0]  wb_dest_reg,
    output logic [1:0]           wb_ctrl_out
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // EX/MEM register
    logic                 r_em_valid;
    logic [word_size-1:0] r_em_alu_result;
    logic                 r_em_zero;
    logic [word_size-1:0] r_em_add_result;
    logic [word_size-1:0] r_em_write_data;
    logic [reg_size-1:0]  r_em_dest_reg;
    logic [2:0]           r_em_mem_ctrl;
    logic [1:0]           r_em_wb_ctrl;

    // MEM/WB register
    logic                 r_wb_valid;
    logic [word_size-1:0] r_wb_read_data;
    logic [word_size-1:0] r_wb_alu_result;
    logic [reg_size-1:0]  r_wb_dest_reg;
    logic [1:0]           r_wb_ctrl;

    logic w_branch;
    logic w_mem_read;
    logic w_mem_write;
    logic w_mem_op;
    logic w_access;
    logic w_done;
    logic w_stall;

    assign w_branch    = r_em_mem_ctrl[2];
    assign w_mem_read  = r_em_mem_ctrl[1];
    assign w_mem_write = r_em_mem_ctrl[0];

    // A branch overrides any memory-control bits that came along with it.
    assign w_mem_op = r_em_valid & ~w_branch & (w_mem_read | w_mem_write);
    assign w_access = (r_state == ACCESS);
    assign w_done   = w_access & dmem_ack;
    assign w_stall  = w_mem_op & ~w_done;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment ahead of the case keeps this purely
    // combinational; a path that leaves w_next_state unassigned infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:   if (w_mem_op) w_next_state = ACCESS;
            ACCESS: if (dmem_ack) w_next_state = IDLE;
        endcase
    end

    // NOTE: reset is synchronous; every field is cleared so stale control bits
    // cannot leak into memory or writeback after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_em_valid      <= 1'b0;
            r_em_alu_result <= '0;
            r_em_zero       <= 1'b0;
            r_em_add_result <= '0;
            r_em_write_data <= '0;
            r_em_dest_reg   <= '0;
            r_em_mem_ctrl   <= '0;
            r_em_wb_ctrl    <= '0;
        end else if (!w_stall) begin
            r_em_valid      <= ex_valid & ~flush;
            r_em_alu_result <= alu_result_in;
            r_em_zero       <= zero_in;
            r_em_add_result <= add_result_in;
            r_em_write_data <= write_data_in;
            r_em_dest_reg   <= dest_reg_in;
            r_em_mem_ctrl   <= mem_ctrl_in;
            r_em_wb_ctrl    <= wb_ctrl_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid      <= 1'b0;
            r_wb_read_data  <= '0;
            r_wb_alu_result <= '0;
            r_wb_dest_reg   <= '0;
            r_wb_ctrl       <= '0;
        end else begin
            if (w_stall) begin
                // Bubble into writeback; data fields keep their last values.
                r_wb_valid <= 1'b0;
                r_wb_ctrl  <= '0;
            end else begin
                r_wb_valid      <= r_em_valid;
                r_wb_ctrl       <= r_em_valid ? r_em_wb_ctrl : 2'b00;
                r_wb_alu_result <= r_em_alu_result;
                r_wb_dest_reg   <= r_em_dest_reg;
            end
            if (w_done && w_mem_read) begin
                r_wb_read_data <= dmem_rdata;
            end
        end
    end

    assign stall         = w_stall;
    assign pc_src        = r_em_valid & w_branch & r_em_zero;
    assign branch_target = r_em_add_result;

    assign dmem_req   = w_access;
    assign dmem_we    = w_mem_write;
    assign dmem_addr  = r_em_alu_result;
    assign dmem_wdata = r_em_write_data;

    assign wb_valid      = r_wb_valid;
    assign wb_read_data  = r_wb_read_data;
    assign wb_alu_result = r_wb_alu_result;
    assign wb_dest_reg   = r_wb_dest_reg;
    assign wb_ctrl_out   = r_wb_ctrl;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] alu_result_in;
    logic        zero_in;
    logic [31:0] add_result_in;
    logic [31:0] write_data_in;
    logic [4:0]  dest_reg_in;
    logic [2:0]  mem_ctrl_in;
    logic [1:0]  wb_ctrl_in;
    logic        flush;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic [31:0] wb_read_data;
    logic [31:0] wb_alu_result;
    logic [4:0]  wb_dest_reg;
    logic [1:0]  wb_ctrl_out;

    mem_stage #(.word_size(32), .reg_size(5)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid),
        .alu_result_in(alu_result_in), .zero_in(zero_in),
        .add_result_in(add_result_in), .write_data_in(write_data_in),
        .dest_reg_in(dest_reg_in), .mem_ctrl_in(mem_ctrl_in),
        .wb_ctrl_in(wb_ctrl_in), .flush(flush), .stall(stall),
        .pc_src(pc_src), .branch_target(branch_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_read_data(wb_read_data),
        .wb_alu_result(wb_alu_result), .wb_dest_reg(wb_dest_reg),
        .wb_ctrl_out(wb_ctrl_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the instruction sitting in EX/MEM, how many cycles it has
    // been there, and the contents of MEM/WB.
    typedef struct {
        logic        v;
        logic [31:0] alu;
        logic        z;
        logic [31:0] add;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [2:0]  mc;
        logic [1:0]  wc;
    } instr_t;

    instr_t      m_em  = '{default: '0};
    int          m_age = 0;
    logic        m_wbv = 1'b0;
    logic [1:0]  m_wbc = '0;
    logic [31:0] m_wbr = '0;
    logic [31:0] m_wba = '0;
    logic [4:0]  m_wbd = '0;

    logic s_stall;
    logic s_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic f_mem_op();
        return m_em.v && !m_em.mc[2] && (m_em.mc[1] || m_em.mc[0]);
    endfunction

    // A memory op spends its first cycle being detected; the request is up from then on.
    function automatic logic f_req();
        return f_mem_op() && (m_age > 0);
    endfunction

    function automatic logic f_stall();
        return f_mem_op() && !(f_req() && dmem_ack);
    endfunction

    task automatic check_all();
        check("stall",         32'(stall),         32'(f_stall()));
        check("pc_src",        32'(pc_src),        32'(m_em.v && m_em.mc[2] && m_em.z));
        check("branch_target", branch_target,      m_em.add);
        check("dmem_req",      32'(dmem_req),      32'(f_req()));
        check("dmem_we",       32'(dmem_we),       32'(m_em.mc[0]));
        check("dmem_addr",     dmem_addr,          m_em.alu);
        check("dmem_wdata",    dmem_wdata,         m_em.wd);
        check("wb_valid",      32'(wb_valid),      32'(m_wbv));
        check("wb_ctrl_out",   32'(wb_ctrl_out),   32'(m_wbc));
        check("wb_read_data",  wb_read_data,       m_wbr);
        check("wb_alu_result", wb_alu_result,      m_wba);
        check("wb_dest_reg",   32'(wb_dest_reg),   32'(m_wbd));
    endtask

    // Advance the model across one clock edge using the inputs applied before it.
    task automatic model_step();
        logic st;
        logic done;
        if (rst) begin
            m_em  = '{default: '0};
            m_age = 0;
            m_wbv = 1'b0;
            m_wbc = '0;
            m_wbr = '0;
            m_wba = '0;
            m_wbd = '0;
        end else begin
            st   = f_stall();
            done = f_req() && dmem_ack;
            if (done && m_em.mc[1]) m_wbr = dmem_rdata;
            if (st) begin
                m_wbv = 1'b0;
                m_wbc = '0;
                m_age++;
            end else begin
                m_wbv = m_em.v;
                m_wbc = m_em.v ? m_em.wc : 2'b00;
                m_wba = m_em.alu;
                m_wbd = m_em.rd;
                m_em  = '{v: ex_valid && !flush, alu: alu_result_in, z: zero_in,
                          add: add_result_in, wd: write_data_in, rd: dest_reg_in,
                          mc: mem_ctrl_in, wc: wb_ctrl_in};
                m_age = 0;
            end
        end
    endtask

    // Called at a falling edge with inputs already applied; returns at the next one.
    task automatic tick();
        #1;
        check_all();
        s_stall = stall;
        s_req   = dmem_req;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ex_valid      = 1'b0;
        alu_result_in = '0;
        zero_in       = 1'b0;
        add_result_in = '0;
        write_data_in = '0;
        dest_reg_in   = '0;
        mem_ctrl_in   = '0;
        wb_ctrl_in    = '0;
        flush         = 1'b0;
        dmem_rdata    = '0;
        dmem_ack      = 1'b0;
    endtask

    task automatic load_instr(input logic [31:0] addr, input logic [4:0] rd);
        ex_valid      = 1'b1;
        alu_result_in = addr;
        dest_reg_in   = rd;
        mem_ctrl_in   = 3'b010;
        wb_ctrl_in    = 2'b11;
    endtask

    initial begin
        int          stall_cnt;
        int          wbv_cnt;
        int          req_cnt;
        logic [4:0]  req_bits;

        clear_inputs();
        rst = 1'b1;
        @(negedge clk);

        // Reset values
        tick();
        rst = 1'b0;
        check("rst_stall",    32'(stall),       32'h0);
        check("rst_pc_src",   32'(pc_src),      32'h0);
        check("rst_dmem_req", 32'(dmem_req),    32'h0);
        check("rst_dmem_we",  32'(dmem_we),     32'h0);
        check("rst_wb_ctrl",  32'(wb_ctrl_out), 32'h0);
        check("rst_wb_valid", 32'(wb_valid),    32'h0);

        // Load at 0x40, ack three cycles after the request rises
        load_instr(32'h40, 5'd7);
        tick();
        stall_cnt = 0;
        wbv_cnt   = 0;
        for (int c = 0; c < 7; c++) begin
            clear_inputs();
            dmem_ack   = (c == 4);
            dmem_rdata = (c == 4) ? 32'hDEADBEEF : 32'h0;
            tick();
            stall_cnt += int'(s_stall);
            wbv_cnt   += int'(wb_valid);
            if (c == 4) begin
                check("load_rdata",   wb_read_data,     32'hDEADBEEF);
                check("load_wb_ctrl", 32'(wb_ctrl_out), 32'h3);
                check("load_dest",    32'(wb_dest_reg), 32'h7);
                check("load_alu",     wb_alu_result,    32'h40);
            end
        end
        check("load_stall_cycles", 32'(stall_cnt), 32'd4);
        check("load_wb_pulses",    32'(wbv_cnt),   32'd1);

        // Store at 0x80, ack in the first request cycle
        ex_valid      = 1'b1;
        alu_result_in = 32'h80;
        write_data_in = 32'h12345678;
        mem_ctrl_in   = 3'b001;
        wb_ctrl_in    = 2'b00;
        tick();
        stall_cnt = 0;
        req_cnt   = 0;
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            dmem_ack = (c == 1);
            if (c == 1) begin
                #1;
                check("store_we",    32'(dmem_we), 32'h1);
                check("store_addr",  dmem_addr,    32'h80);
                check("store_wdata", dmem_wdata,   32'h12345678);
            end
            tick();
            stall_cnt += int'(s_stall);
            req_cnt   += int'(s_req);
            if (c == 1) begin
                check("store_wb_valid", 32'(wb_valid),    32'h1);
                check("store_wb_ctrl",  32'(wb_ctrl_out), 32'h0);
            end
        end
        check("store_stall_cycles", 32'(stall_cnt), 32'd1);
        check("store_req_cycles",   32'(req_cnt),   32'd1);

        // Branch taken, then not taken with stray memory bits
        ex_valid      = 1'b1;
        mem_ctrl_in   = 3'b100;
        zero_in       = 1'b1;
        add_result_in = 32'h1000;
        tick();
        clear_inputs();
        check("br_taken_pc_src", 32'(pc_src),   32'h1);
        check("br_target",       branch_target, 32'h1000);
        check("br_no_req",       32'(dmem_req), 32'h0);
        tick();
        check("br_one_cycle",    32'(pc_src),   32'h0);
        ex_valid      = 1'b1;
        mem_ctrl_in   = 3'b110;
        zero_in       = 1'b0;
        add_result_in = 32'h1000;
        tick();
        clear_inputs();
        check("br_nt_pc_src", 32'(pc_src), 32'h0);
        check("br_nt_stall",  32'(stall),  32'h0);
        tick();
        check("br_nt_no_req", 32'(s_req),  32'h0);

        // Flushed R-type never reaches writeback; unflushed one does
        ex_valid    = 1'b1;
        flush       = 1'b1;
        wb_ctrl_in  = 2'b10;
        dest_reg_in = 5'd9;
        tick();
        clear_inputs();
        tick();
        check("flush_wb_valid", 32'(wb_valid),    32'h0);
        check("flush_wb_ctrl",  32'(wb_ctrl_out), 32'h0);
        ex_valid    = 1'b1;
        wb_ctrl_in  = 2'b10;
        dest_reg_in = 5'd9;
        tick();
        clear_inputs();
        tick();
        check("rtype_wb_valid", 32'(wb_valid),    32'h1);
        check("rtype_wb_ctrl",  32'(wb_ctrl_out), 32'h2);

        // Stray ack while idle, then two back-to-back loads
        dmem_ack = 1'b1;
        tick();
        check("stray_req",   32'(s_req),   32'h0);
        check("stray_stall", 32'(s_stall), 32'h0);
        tick();
        dmem_ack = 1'b0;
        load_instr(32'h100, 5'd3);
        tick();
        load_instr(32'h104, 5'd4);
        req_bits = '0;
        for (int c = 0; c < 5; c++) begin
            if (c >= 2) ex_valid = 1'b0;
            dmem_ack   = (c == 1) || (c == 3);
            dmem_rdata = (c == 1) ? 32'hAAAA0001 : ((c == 3) ? 32'hBBBB0002 : 32'h0);
            tick();
            req_bits[c] = s_req;
            if (c == 1) begin
                check("b2b_first_rdata", wb_read_data,     32'hAAAA0001);
                check("b2b_first_dest",  32'(wb_dest_reg), 32'h3);
            end
            if (c == 3) begin
                check("b2b_second_rdata", wb_read_data,     32'hBBBB0002);
                check("b2b_second_dest",  32'(wb_dest_reg), 32'h4);
            end
        end
        check("b2b_req_pattern", 32'(req_bits), 32'h0A);
        clear_inputs();

        // Reset while an access is outstanding
        load_instr(32'h200, 5'd5);
        tick();
        clear_inputs();
        tick();
        check("midrst_req_before", 32'(dmem_req), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_req",      32'(dmem_req), 32'h0);
        check("midrst_stall",    32'(stall),    32'h0);
        check("midrst_wb_valid", 32'(wb_valid), 32'h0);
        tick();
        check("midrst_stays_idle", 32'(s_req), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 149) == 0);
            ex_valid      = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 7) == 0);
            alu_result_in = $urandom;
            zero_in       = 1'($urandom_range(0, 1));
            add_result_in = $urandom;
            write_data_in = $urandom;
            dest_reg_in   = 5'($urandom_range(0, 31));
            wb_ctrl_in    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       mem_ctrl_in = 3'b000;
                1:       mem_ctrl_in = 3'b010;
                2:       mem_ctrl_in = 3'b001;
                3:       mem_ctrl_in = 3'b100;
                4:       mem_ctrl_in = {1'b1, 2'($urandom_range(1, 3))};
                default: mem_ctrl_in = 3'($urandom_range(0, 7));
            endcase
            dmem_ack   = ($urandom_range(0, 2) == 0);
            dmem_rdata = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
